// File: rtl/des_decrypt_core.sv
// -----------------------------------------------------------------------------
// des_decrypt_core -- iterative single-DES decryption, one Feistel round/clock.
//
// Ports
//   clk     in  1       rising-edge clock
//   rst     in  1       asynchronous active-high reset
//   start   in  1       accept data_i/key_i when idle
//   data_i  in  [1:64]  ciphertext, bit 1 = MSB (FIPS 46 numbering)
//   key_i   in  [1:64]  key incl. parity bits 8,16,..,64 (ignored)
//   busy    out 1       rounds in progress
//   done    out 1       one-cycle pulse, data_o valid from here on
//   data_o  out [1:64]  plaintext, held until the next FINISH
//
// Subkeys are produced in reverse order by rotating C,D right after each round.
// The right-rotation amounts sum to 28, so C,D end where PC-1 left them and
// the first round (K16) needs no pre-rotation.
//
// Also contains the round primitives: e_expansion, s_boxes (8 x des_sbox) and
// p_permutation.
// -----------------------------------------------------------------------------

// E expansion: 32 -> 48 bits.
module e_expansion (
  input  logic [1:32] r,
  output logic [1:48] e
);
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  for (genvar i = 0; i < 48; i++) begin : g_e
    assign e[i+1] = r[E_T[i]];
  end
endmodule

// Single S-box lookup; IDX selects S1..S8 (0-based).
module des_sbox #(
  parameter int IDX = 0
) (
  input  logic [1:6] b,
  output logic [1:4] y
);
  // Flat 64-entry tables, index = row*16 + col.
  localparam int SBOX [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
       0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
      15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
       3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
      13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
       1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
      13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
       3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
      14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
      11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
      10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
       4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
      13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
       6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
       1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
       2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  // Row = outer bits {b1,b6}, column = inner bits b2..b5.
  assign y = 4'(SBOX[IDX][{b[1], b[6], b[2:5]}]);
endmodule

// Eight S-boxes side by side: 48 -> 32 bits.
module s_boxes (
  input  logic [1:48] x,
  output logic [1:32] y
);
  for (genvar i = 0; i < 8; i++) begin : g_sb
    des_sbox #(.IDX(i)) u_sbox (
      .b (x[6*i+1 : 6*i+6]),
      .y (y[4*i+1 : 4*i+4])
    );
  end
endmodule

// P permutation: 32 -> 32 bits.
module p_permutation (
  input  logic [1:32] x,
  output logic [1:32] y
);
  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25};

  for (genvar i = 0; i < 32; i++) begin : g_p
    assign y[i+1] = x[P_T[i]];
  end
endmodule

module des_decrypt_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:64] data_i,
  input  logic [1:64] key_i,
  output logic        busy,
  output logic        done,
  output logic [1:64] data_o
);
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,  60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,  64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,  59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,  63, 55, 47, 39, 31, 23, 15,  7};

  localparam int IPINV_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,  39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,  37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,  35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,  33,  1, 41,  9, 49, 17, 57, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  typedef enum logic [1:0] {IDLE, ROUND, FINISH} state_t;

  state_t      state;
  logic [1:32] l, r;
  logic [1:28] c, d;
  logic [4:0]  cnt;

  logic [1:64] ip_in, rl, ipinv_out;
  logic [1:56] pc1_key, cd;
  logic [1:48] subkey, e_r;
  logic [1:32] s_out, f_out;
  logic        rot2;
  logic        parity_unused;

  assign rl = {r, l};
  assign cd = {c, d};

  for (genvar i = 0; i < 64; i++) begin : g_ip
    assign ip_in[i+1]     = data_i[IP_T[i]];
    assign ipinv_out[i+1] = rl[IPINV_T[i]];
  end

  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_key[i+1] = key_i[PC1_T[i]];
  end

  // Subkey comes from C,D as they stand this round, before rotation.
  for (genvar i = 0; i < 48; i++) begin : g_pc2
    assign subkey[i+1] = cd[PC2_T[i]];
  end

  // Parity bits never reach the datapath.
  assign parity_unused = ^{key_i[8], key_i[16], key_i[24], key_i[32],
                           key_i[40], key_i[48], key_i[56], key_i[64]};

  e_expansion   u_e (.r(r),             .e(e_r));
  s_boxes       u_s (.x(e_r ^ subkey),  .y(s_out));
  p_permutation u_p (.x(s_out),         .y(f_out));

  // Reverse key schedule: single-step rotations after rounds 1, 8, 15, 16.
  assign rot2 = !(cnt == 5'd1 || cnt == 5'd8 || cnt == 5'd15 || cnt == 5'd16);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      l      <= '0;
      r      <= '0;
      c      <= '0;
      d      <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      data_o <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            l     <= ip_in[1:32];
            r     <= ip_in[33:64];
            c     <= pc1_key[1:28];
            d     <= pc1_key[29:56];
            cnt   <= 5'd1;
            busy  <= 1'b1;
            state <= ROUND;
          end
        end
        ROUND: begin
          l <= r;
          r <= l ^ f_out;
          if (rot2) begin
            c <= {c[27:28], c[1:26]};
            d <= {d[27:28], d[1:26]};
          end else begin
            c <= {c[28], c[1:27]};
            d <= {d[28], d[1:27]};
          end
          // Counter parks at 16 so it never leaves 1..16.
          if (cnt == 5'd16) state <= FINISH;
          else              cnt   <= cnt + 5'd1;
        end
        FINISH: begin
          // Undo the last round's swap: output is IP^-1(R||L).
          data_o <= ipinv_out;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
